pot_scan_sched: RTL and testbench

Round-robin scheduler that shares the single SPI A2D converter among the six equalizer slide potentiometers. It issues conversion requests channel by channel, waits for each result with a timeout guard, and holds the latest 12-bit reading per pot. Those registers drive the POT_LP, POT_B1, POT_B2, POT_B3, POT_HP and POT_VOL inputs of the digital equalizer core.

---
 rtl/pot_scan_sched.sv | 173 +++++++++++++++++
 tb/tb_pot_scan_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scan_sched.sv
// pot_scan_sched
// Round-robin scheduler sharing one SPI A2D converter among the six
// equalizer slide pots. Each slot issues a one-cycle conversion request,
// waits for the result (or a timeout), latches it, then idles GAP cycles
// before moving on to the next slot.
//
// Parameters:
//   GAP       idle cycles between the end of one conversion and the next start (>= 2)
//   TIMEOUT   cycles to wait for cnv_cmplt, counted from the strt_cnv cycle (>= 2)
// Ports:
//   clk        system clock, posedge
//   rst_n      asynchronous reset, active-HIGH despite the name
//   en         scan enable; a conversion in flight always finishes
//   cnv_cmplt  one-cycle completion pulse from the A2D, res valid with it
//   res        12-bit A2D result
//   strt_cnv   one-cycle conversion request
//   chnnl      A2D channel select, decoded from the slot index
//   POT_*      latest reading per pot (bands reset to 12'h800, VOL to 12'h000)
//   sweep_done one-cycle pulse when the VOL slot is resolved
//   pots_valid sticky, set at the first sweep end with no timeouts
//   err        one-cycle pulse on a conversion timeout
module pot_scan_sched #(
  parameter int GAP     = 1024,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  output logic [11:0] POT_LP,
  output logic [11:0] POT_B1,
  output logic [11:0] POT_B2,
  output logic [11:0] POT_B3,
  output logic [11:0] POT_HP,
  output logic [11:0] POT_VOL,
  output logic        sweep_done,
  output logic        pots_valid,
  output logic        err
);

  localparam int GW = (GAP > 2) ? $clog2(GAP) : 1;
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, ADV} state_t;

  state_t      state_q;
  logic [2:0]  idx_q;
  logic [GW-1:0] gapCnt_q;
  logic [TW-1:0] tmoCnt_q;
  logic        strt_q;
  logic        done_q;
  logic        err_q;
  logic        valid_q;
  logic        bad_q;
  logic [11:0] potLp_q, potB1_q, potB2_q, potB3_q, potHp_q, potVol_q;

  // Slot index to A2D channel: LP, B1, B2, B3, HP, VOL.
  always_comb begin
    chnnl = 3'd1;
    case (idx_q)
      3'd0:    chnnl = 3'd1;
      3'd1:    chnnl = 3'd0;
      3'd2:    chnnl = 3'd4;
      3'd3:    chnnl = 3'd2;
      3'd4:    chnnl = 3'd3;
      3'd5:    chnnl = 3'd7;
      default: chnnl = 3'd1;
    endcase
  end

  // Scheduler FSM with registered pulse outputs. The timeout counter is
  // cleared on entry to START and also counts the START cycle, so err lands
  // exactly TIMEOUT cycles after the strt_cnv cycle. bad_q records any
  // timeout since the last wrap and gates pots_valid at sweep end.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      gapCnt_q <= '0;
      tmoCnt_q <= '0;
      strt_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      bad_q    <= 1'b0;
      potLp_q  <= 12'h800;
      potB1_q  <= 12'h800;
      potB2_q  <= 12'h800;
      potB3_q  <= 12'h800;
      potHp_q  <= 12'h800;
      potVol_q <= 12'h000;
    end else begin
      strt_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!en) begin
            gapCnt_q <= '0;
          end else if (gapCnt_q == GAP_LAST) begin
            gapCnt_q <= '0;
            tmoCnt_q <= '0;
            strt_q   <= 1'b1;
            state_q  <= START;
          end else begin
            gapCnt_q <= gapCnt_q + 1'b1;
          end
        end
        START: begin
          tmoCnt_q <= tmoCnt_q + 1'b1;
          state_q  <= WAIT;
        end
        WAIT: begin
          // A result on the timeout cycle still counts as a result.
          if (cnv_cmplt) begin
            case (idx_q)
              3'd0:    potLp_q  <= res;
              3'd1:    potB1_q  <= res;
              3'd2:    potB2_q  <= res;
              3'd3:    potB3_q  <= res;
              3'd4:    potHp_q  <= res;
              default: potVol_q <= res;
            endcase
            state_q <= ADV;
            if (idx_q == 3'd5) begin
              done_q <= 1'b1;
              if (!bad_q) begin
                valid_q <= 1'b1;
              end
            end
          end else if (tmoCnt_q == TMO_LAST) begin
            err_q   <= 1'b1;
            bad_q   <= 1'b1;
            state_q <= ADV;
            if (idx_q == 3'd5) begin
              done_q <= 1'b1;
            end
          end else begin
            tmoCnt_q <= tmoCnt_q + 1'b1;
          end
        end
        ADV: begin
          if (idx_q == 3'd5) begin
            idx_q <= 3'd0;
            bad_q <= 1'b0;
          end else begin
            idx_q <= idx_q + 3'd1;
          end
          gapCnt_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign strt_cnv   = strt_q;
  assign sweep_done = done_q;
  assign err        = err_q;
  assign pots_valid = valid_q;
  assign POT_LP     = potLp_q;
  assign POT_B1     = potB1_q;
  assign POT_B2     = potB2_q;
  assign POT_B3     = potB3_q;
  assign POT_HP     = potHp_q;
  assign POT_VOL    = potVol_q;

endmodule

// File: tb/tb_pot_scan_sched.sv
// tb_pot_scan_sched
// Directed bench for pot_scan_sched (GAP=4, TIMEOUT=64). A behavioural A2D
// answers each request after a per-channel delay with a per-channel result
// (default ch*100 after 20 cycles); a delay of 0 drops the answer.
module tb_pot_scan_sched;

  localparam int GAP     = 4;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv;
  logic [2:0]  chnnl;
  logic [11:0] POT_LP, POT_B1, POT_B2, POT_B3, POT_HP, POT_VOL;
  logic        sweep_done, pots_valid, err;

  always #5 clk = ~clk;

  pot_scan_sched #(.GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cnv_cmplt(cnv_cmplt), .res(res),
    .strt_cnv(strt_cnv), .chnnl(chnnl),
    .POT_LP(POT_LP), .POT_B1(POT_B1), .POT_B2(POT_B2), .POT_B3(POT_B3),
    .POT_HP(POT_HP), .POT_VOL(POT_VOL),
    .sweep_done(sweep_done), .pots_valid(pots_valid), .err(err)
  );

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] pot;
  } slot_t;

  slot_t       tbl[6];
  int          compared   = 0;
  int          mismatched = 0;
  int          delayFor[8];
  logic [11:0] resFor[8];
  int          strayReqs = 0;
  logic [11:0] strayRes  = 12'h123;
  logic [11:0] curPot[6];

  // A2D model: drives 1 time unit after each posedge, main flow samples at 2.
  initial begin
    int          countdown;
    int          strayDone;
    logic [11:0] pend;
    countdown = 0;
    strayDone = 0;
    pend      = '0;
    cnv_cmplt = 1'b0;
    res       = '0;
    forever begin
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
      if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          cnv_cmplt = 1'b1;
          res       = pend;
        end
      end else if (strayReqs != strayDone) begin
        cnv_cmplt = 1'b1;
        res       = strayRes;
        strayDone++;
      end
      if (strt_cnv === 1'b1 && delayFor[chnnl] != 0) begin
        countdown = delayFor[chnnl];
        pend      = resFor[chnnl];
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] potOf(input int slot);
    case (slot)
      0:       return POT_LP;
      1:       return POT_B1;
      2:       return POT_B2;
      3:       return POT_B3;
      4:       return POT_HP;
      default: return POT_VOL;
    endcase
  endfunction

  // Returns the number of cycles until strt_cnv is seen (0 if already high).
  task automatic waitStrt(input string nm, output int n);
    n = 0;
    while (strt_cnv !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    checkOutput({nm, "_strt_seen"}, 32'(strt_cnv), 1);
  endtask

  // One slot: request, resolution (result or timeout), ends in the ADV cycle.
  task automatic applyStimulus(input int i, input bit expTmo, input logic [11:0] expPot,
                               input int enDropAfter, input bit checkGap);
    int n;
    int w;
    bit errSeen;
    string nm;
    nm = $sformatf("slot%0d", i);
    waitStrt(nm, n);
    if (checkGap) checkOutput({nm, "_gap_to_strt"}, n, GAP + 1);
    checkOutput({nm, "_chnnl"}, 32'(chnnl), 32'(tbl[i].ch));
    w = 0;
    errSeen = 1'b0;
    if (expTmo) begin
      while (err !== 1'b1 && w < 200) begin
        tick();
        w++;
        if (w == enDropAfter) en = 1'b0;
      end
      checkOutput({nm, "_err_latency"}, w, TIMEOUT);
    end else begin
      while (cnv_cmplt !== 1'b1 && w < 200) begin
        tick();
        w++;
        if (err === 1'b1) errSeen = 1'b1;
        if (w == enDropAfter) en = 1'b0;
      end
      checkOutput({nm, "_cmplt_seen"}, 32'(cnv_cmplt), 1);
      tick();
      checkOutput({nm, "_no_err"}, 32'(err | errSeen), 0);
    end
    checkOutput({nm, "_pot"}, 32'(potOf(i)), 32'(expPot));
    checkOutput({nm, "_sweep_done"}, 32'(sweep_done), 32'(i == 5));
  endtask

  task automatic checkResetValues(input string nm);
    for (int s = 0; s < 5; s++) checkOutput($sformatf("%s_pot%0d", nm, s), 32'(potOf(s)), 32'h800);
    checkOutput({nm, "_vol"}, 32'(POT_VOL), 0);
    checkOutput({nm, "_chnnl"}, 32'(chnnl), 1);
    checkOutput({nm, "_strt"}, 32'(strt_cnv), 0);
    checkOutput({nm, "_sweep_done"}, 32'(sweep_done), 0);
    checkOutput({nm, "_err"}, 32'(err), 0);
    checkOutput({nm, "_pots_valid"}, 32'(pots_valid), 0);
  endtask

  initial begin
    int n;
    int strtCount;
    tbl[0] = '{3'd1, 12'd100};
    tbl[1] = '{3'd0, 12'd0};
    tbl[2] = '{3'd4, 12'd400};
    tbl[3] = '{3'd2, 12'd200};
    tbl[4] = '{3'd3, 12'd300};
    tbl[5] = '{3'd7, 12'd700};
    for (int c = 0; c < 8; c++) begin
      delayFor[c] = 20;
      resFor[c]   = 12'(c * 100);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (3) tick();
    checkResetValues("reset");

    // Steady scan: first request GAP cycles after reset release.
    rst_n = 1'b0;
    waitStrt("first", n);
    checkOutput("first_strt_cycle", n, GAP);
    for (int i = 0; i < 6; i++) applyStimulus(i, 1'b0, tbl[i].pot, -1, i > 0);
    checkOutput("sweep1_pots_valid", 32'(pots_valid), 1);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("sweep1_final_pot%0d", i), 32'(potOf(i)), 32'(tbl[i].pot));

    // Timeout on ch4 in a fresh sweep.
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    checkOutput("rst2_pots_valid", 32'(pots_valid), 0);
    delayFor[4] = 0;
    for (int i = 0; i < 6; i++) applyStimulus(i, i == 2, (i == 2) ? 12'h800 : tbl[i].pot, -1, i > 0);
    checkOutput("tmo_sweep_pots_valid", 32'(pots_valid), 0);
    delayFor[4] = 20;
    for (int i = 0; i < 6; i++) applyStimulus(i, 1'b0, tbl[i].pot, -1, 1'b1);
    checkOutput("clean_sweep_pots_valid", 32'(pots_valid), 1);

    // Result arriving on the exact timeout cycle.
    delayFor[1] = TIMEOUT - 1;
    resFor[1]   = 12'hABC;
    applyStimulus(0, 1'b0, 12'hABC, -1, 1'b1);
    delayFor[1] = 20;
    resFor[1]   = 12'd100;

    // en dropped during WAIT of B3, then a long park with a stray pulse.
    applyStimulus(1, 1'b0, 12'd0, -1, 1'b1);
    applyStimulus(2, 1'b0, 12'd400, -1, 1'b1);
    applyStimulus(3, 1'b0, 12'd200, 5, 1'b1);
    curPot[0] = 12'hABC; curPot[1] = 12'd0;   curPot[2] = 12'd400;
    curPot[3] = 12'd200; curPot[4] = 12'd300; curPot[5] = 12'd700;
    strtCount = 0;
    for (int k = 0; k < 500; k++) begin
      tick();
      if (k == 10) strayReqs++;
      if (strt_cnv === 1'b1) strtCount++;
    end
    checkOutput("park_no_strt", strtCount, 0);
    checkOutput("park_chnnl", 32'(chnnl), 3);
    for (int i = 0; i < 6; i++) checkOutput($sformatf("park_pot%0d", i), 32'(potOf(i)), 32'(curPot[i]));
    en = 1'b1;
    waitStrt("resume", n);
    checkOutput("resume_strt_cycle", n, GAP);
    applyStimulus(4, 1'b0, 12'd300, -1, 1'b0);
    applyStimulus(5, 1'b0, 12'd700, -1, 1'b1);
    checkOutput("resume_pots_valid", 32'(pots_valid), 1);

    // Reset mid-WAIT: asynchronous clear, late answer lands in IDLE.
    waitStrt("pre_rst", n);
    checkOutput("pre_rst_gap", n, GAP + 1);
    repeat (5) tick();
    rst_n = 1'b1;
    en    = 1'b0;
    #1;
    checkResetValues("async_rst");
    tick();
    rst_n = 1'b0;
    repeat (30) tick();
    checkOutput("late_cmplt_lp", 32'(POT_LP), 32'h800);
    checkOutput("late_cmplt_chnnl", 32'(chnnl), 1);
    en = 1'b1;
    waitStrt("restart", n);
    checkOutput("restart_strt_cycle", n, GAP);
    applyStimulus(0, 1'b0, 12'd100, -1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
